// File: rtl/ppu_pkg.sv
// Shared posit-unit sizing helpers; widths derive from the posit width so
// pack_fields and the encoder ports line up without casts.
package ppu_pkg;

  // Signed regime width: holds +/-(N-2).
  function automatic int k_size(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int mant_size(input int n);
    return n - 2;
  endfunction

  function automatic int reg_len_size(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int mant_len_size(input int n);
    return $clog2(n - 2) + 1;
  endfunction

endpackage

// File: rtl/build_body.sv
// Combinational posit body assembly: regime, exponent and fraction packed
// MSB-first into the N-1 bits below the sign.
module build_body import ppu_pkg::*; #(
  parameter int N  = 4,
  parameter int ES = 0,
  localparam int K_SIZE    = k_size(N),
  localparam int MANT_SIZE = mant_size(N),
  localparam int ES_W      = (ES > 0) ? ES : 1
) (
  input  logic signed [K_SIZE-1:0]    k_i,
  input  logic        [ES_W-1:0]      next_exp_i,
  input  logic        [MANT_SIZE-1:0] frac_i,
  input  logic                        nz_frac_i,
  output logic        [N-2:0]         body_o
);

  int kk, rl, fl;

  always_comb begin
    body_o = '0;
    kk     = int'(k_i);
    rl     = (kk >= 0) ? kk + 2 : 1 - kk;
    fl     = N - 1 - ES - rl;
    // i counts from the MSB of the body; bits past body[0] simply never land.
    for (int i = 0; i < N - 1; i++) begin
      if (i < rl) begin
        body_o[N-2-i] = (kk >= 0) ? (i <= kk) : (i >= -kk);
      end else if (ES > 0 && i < rl + ES) begin
        body_o[N-2-i] = next_exp_i[ES-1-(i-rl)];
      end
    end
    if (nz_frac_i) begin
      for (int i = 0; i < MANT_SIZE; i++) begin
        if (i < fl) body_o[i] = body_o[i] | frac_i[i];
      end
    end
  end

endmodule

// File: rtl/posit_pack_pipe.sv
// Two-stage posit encoder: stage 1 assembles the body, stage 2 rounds
// (RNE, saturating), applies sign and specials. Valid/ready on both sides.
module posit_pack_pipe import ppu_pkg::*; #(
  parameter int N  = 4,
  parameter int ES = 0,
  localparam int K_SIZE    = k_size(N),
  localparam int MANT_SIZE = mant_size(N),
  localparam int ES_W      = (ES > 0) ? ES : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        sign,
  input  logic                        is_zero,
  input  logic                        is_nar,
  input  logic signed [K_SIZE-1:0]    k,
`ifndef NO_ES_FIELD
  input  logic        [ES_W-1:0]      next_exp,
`endif
  input  logic        [MANT_SIZE-1:0] frac,
  input  logic                        round_bit,
  input  logic                        sticky_bit,
  input  logic                        k_is_oob,
  input  logic                        non_zero_frac_field_size,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic        [N-1:0]         posit
);

`ifdef NO_ES_FIELD
  logic [ES_W-1:0] next_exp;
  assign next_exp = '0;
`endif

  logic         s1_valid_q, s2_valid_q;
  logic         s1_adv, s2_adv, in_fire;
  logic [N-2:0] body_d, body_q;
  logic         sign_q, zero_q, nar_q, rb_q, st_q, oob_q;
  logic [N-1:0] posit_d, posit_q;

  build_body #(.N(N), .ES(ES)) u_body (
    .k_i        (k),
    .next_exp_i (next_exp),
    .frac_i     (frac),
    .nz_frac_i  (non_zero_frac_field_size),
    .body_o     (body_d)
  );

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = s1_valid_q & s2_adv;
  assign in_ready = ~s1_valid_q | s1_adv;
  assign in_fire  = in_valid & in_ready;

  // Saturating RNE: never rounds past maxpos, never rounds a clamped regime.
  logic         inc;
  logic [N-2:0] rbody;
  logic [N-1:0] mag;

  always_comb begin
    inc   = rb_q & (st_q | body_q[0]) & ~oob_q & ~(&body_q);
    rbody = body_q + {{(N-2){1'b0}}, inc};
    mag   = {1'b0, rbody};
    if (nar_q)       posit_d = {1'b1, {(N-1){1'b0}}};
    else if (zero_q) posit_d = '0;
    else if (sign_q) posit_d = -mag;
    else             posit_d = mag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      body_q     <= '0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      nar_q      <= 1'b0;
      rb_q       <= 1'b0;
      st_q       <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid_q <= 1'b1;
        body_q     <= body_d;
        sign_q     <= sign;
        zero_q     <= is_zero;
        nar_q      <= is_nar;
        rb_q       <= round_bit;
        st_q       <= sticky_bit;
        oob_q      <= k_is_oob;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      posit_q    <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) posit_q <= posit_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign posit     = posit_q;

endmodule

// File: tb/tb_posit_pack_pipe.sv
// Directed bench for posit_pack_pipe at N=8, ES=0.
module tb_posit_pack_pipe;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic              sign, is_zero, is_nar;
  logic signed [3:0] k;
  logic [0:0]        next_exp;
  logic [5:0]        frac;
  logic              round_bit, sticky_bit, k_is_oob, nzf;
  logic              out_valid, out_ready;
  logic [7:0]        posit;

  int checks = 0;
  int errors = 0;

  posit_pack_pipe #(.N(8), .ES(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign(sign), .is_zero(is_zero), .is_nar(is_nar), .k(k),
    .next_exp(next_exp), .frac(frac), .round_bit(round_bit),
    .sticky_bit(sticky_bit), .k_is_oob(k_is_oob),
    .non_zero_frac_field_size(nzf), .out_valid(out_valid),
    .out_ready(out_ready), .posit(posit)
  );

  always #5 clk = ~clk;

  task automatic set_fields(input logic s, input logic z, input logic n,
                            input logic signed [3:0] kv, input logic [5:0] f,
                            input logic rb, input logic st, input logic oob);
    sign = s; is_zero = z; is_nar = n; k = kv; frac = f;
    round_bit = rb; sticky_bit = st; k_is_oob = oob; nzf = 1'b1;
    next_exp = 1'b0;
  endtask

  // Drives one word, returns the posit seen and the negedge count until out_valid.
  task automatic send_and_get(input logic s, input logic z, input logic n,
                              input logic signed [3:0] kv, input logic [5:0] f,
                              input logic rb, input logic st, input logic oob,
                              output logic [7:0] p, output int lat);
    @(negedge clk);
    set_fields(s, z, n, kv, f, rb, st, oob);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    p = posit;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_fields(0, 0, 0, 4'sd0, 6'd0, 0, 0, 0);
    #12;
    checks++;
    if (out_valid !== 1'b0 || posit !== 8'h00) begin
      errors++;
      $display("FAIL reset_state out_valid=%b posit=%h required 0/00", out_valid, posit);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_unity;
    logic [7:0] p; int lat;
    send_and_get(0, 0, 0, 4'sd0, 6'd0, 0, 0, 0, p, lat);
    checks++;
    if (p !== 8'h40) begin
      errors++; $display("FAIL unity posit=%h required 40", p);
    end
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL latency got %0d required 2", lat);
    end
  endtask

  task automatic test_rne;
    logic [7:0] p; int lat;
    send_and_get(0, 0, 0, 4'sd0, 6'b010101, 1, 0, 0, p, lat);
    checks++;
    if (p !== 8'h56) begin
      errors++; $display("FAIL rne_odd posit=%h required 56", p);
    end
    send_and_get(0, 0, 0, 4'sd0, 6'b010100, 1, 0, 0, p, lat);
    checks++;
    if (p !== 8'h54) begin
      errors++; $display("FAIL rne_tie_even posit=%h required 54", p);
    end
    send_and_get(0, 0, 0, 4'sd0, 6'b010100, 1, 1, 0, p, lat);
    checks++;
    if (p !== 8'h55) begin
      errors++; $display("FAIL rne_sticky posit=%h required 55", p);
    end
  endtask

  task automatic test_sign_specials;
    logic [7:0] p; int lat;
    send_and_get(1, 0, 0, 4'sd0, 6'd0, 0, 0, 0, p, lat);
    checks++;
    if (p !== 8'hC0) begin
      errors++; $display("FAIL neg_unity posit=%h required C0", p);
    end
    send_and_get(1, 0, 0, 4'sd0, 6'b010101, 1, 0, 0, p, lat);
    checks++;
    if (p !== 8'hAA) begin
      errors++; $display("FAIL neg_rounded posit=%h required AA", p);
    end
    send_and_get(0, 1, 1, 4'sd0, 6'd0, 0, 0, 0, p, lat);
    checks++;
    if (p !== 8'h80) begin
      errors++; $display("FAIL nar_priority posit=%h required 80", p);
    end
    send_and_get(1, 1, 0, 4'sd2, 6'd3, 1, 1, 0, p, lat);
    checks++;
    if (p !== 8'h00) begin
      errors++; $display("FAIL zero posit=%h required 00", p);
    end
  endtask

  task automatic test_saturation;
    logic [7:0] p; int lat;
    send_and_get(0, 0, 0, 4'sd6, 6'd0, 1, 1, 1, p, lat);
    checks++;
    if (p !== 8'h7F) begin
      errors++; $display("FAIL maxpos posit=%h required 7F", p);
    end
    send_and_get(0, 0, 0, -4'sd6, 6'd0, 0, 0, 0, p, lat);
    checks++;
    if (p !== 8'h01) begin
      errors++; $display("FAIL minpos posit=%h required 01", p);
    end
    send_and_get(0, 0, 0, -4'sd6, 6'd0, 1, 1, 0, p, lat);
    checks++;
    if (p !== 8'h02) begin
      errors++; $display("FAIL minpos_round posit=%h required 02", p);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] got[$];
    logic [7:0] exp_q[3];
    logic       stable_ok;
    exp_q[0] = 8'h40; exp_q[1] = 8'h60; exp_q[2] = 8'h20;
    @(negedge clk);
    out_ready = 1'b0;
    set_fields(0, 0, 0, 4'sd0, 6'd0, 0, 0, 0);
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    set_fields(0, 0, 0, 4'sd1, 6'd0, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    set_fields(0, 0, 0, -4'sd1, 6'd0, 0, 0, 0);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_stall in_ready=%b out_valid=%b required 0/1", in_ready, out_valid);
    end
    got.push_back(posit);
    stable_ok = 1'b1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      if (posit !== 8'h40 || out_valid !== 1'b1 || in_ready !== 1'b0) stable_ok = 1'b0;
    end
    checks++;
    if (!stable_ok) begin
      errors++;
      $display("FAIL stall_hold posit=%h out_valid=%b in_ready=%b required 40/1/0",
               posit, out_valid, in_ready);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL release_in_ready got %b required 1", in_ready);
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid === 1'b1) got.push_back(posit);
      @(negedge clk);
    end
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL bp_count got %0d words required 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          errors++; $display("FAIL bp_order word %0d posit=%h required %h", i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight;
    logic [7:0] p; int lat;
    logic       quiet;
    @(negedge clk);
    out_ready = 1'b0;
    set_fields(0, 0, 0, 4'sd0, 6'd0, 0, 0, 0);
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    set_fields(0, 0, 0, 4'sd1, 6'd0, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || posit !== 8'h40) begin
      errors++; $display("FAIL prefill out_valid=%b posit=%h required 1/40", out_valid, posit);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || posit !== 8'h00) begin
      errors++;
      $display("FAIL async_reset out_valid=%b posit=%h required 0/00", out_valid, posit);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++; $display("FAIL stale_output out_valid seen after reset, required none");
    end
    send_and_get(0, 0, 0, -4'sd1, 6'd0, 0, 0, 0, p, lat);
    checks++;
    if (p !== 8'h20 || lat !== 2) begin
      errors++; $display("FAIL post_reset_word posit=%h lat=%0d required 20/2", p, lat);
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_rne();
    test_sign_specials();
    test_saturation();
    test_backpressure();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/posit_pack_pipe.md
# posit_pack_pipe

Two-stage pipelined posit encoder that sits directly downstream of `pack_fields`. It takes the clamped regime `k`, the truncated exponent, the right-aligned fraction and the rounding flags, and produces the final N-bit posit word. It assembles the regime/exponent/fraction body, applies round-to-nearest-even with saturation, handles sign and the zero/NaR specials, and exposes a valid/ready handshake on both sides so the arithmetic core can stall.

## Interface
- `N`, 4: posit width.
- `ES`, 0: exponent field width. When built with `NO_ES_FIELD`, the `next_exp` port is absent and treated as zero.
- `clk` input, 1: clock.
- `rst` input, 1: reset, asynchronous, active-high.
- `in_valid` input, 1: upstream fields valid.
- `in_ready` output, 1: stage 1 can accept.
- `sign` input, 1: result sign.
- `is_zero` input, 1: force result to zero.
- `is_nar` input, 1: force result to NaR; takes priority over `is_zero`.
- `k` input, K_SIZE: signed regime, already clamped to ±(N-2).
- `next_exp` input, ES: exponent bits, left-aligned within ES.
- `frac` input, MANT_SIZE: fraction, right-aligned; low `frac_len` bits are significant.
- `round_bit` input, 1: guard bit.
- `sticky_bit` input, 1: OR of the bits below the guard.
- `k_is_oob` input, 1: regime was clamped.
- `non_zero_frac_field_size` input, 1: fraction field exists.
- `out_valid` output, 1: `posit` valid.
- `out_ready` input, 1: downstream accepts.
- `posit` output, N: encoded result.

## Operation
- **Stage 1 (assemble)** builds the unsigned body `body[N-2:0]`.
  - `reg_len` = k+2 when k≥0, otherwise −k+1.
  - Regime for k≥0: k+1 ones followed by a 0. Regime for k<0: −k zeros followed by a 1.
  - The regime is placed MSB-first at body[N-2]. At k=±(N-2) the terminating bit falls off the end.
  - `next_exp` MSB is placed immediately after the regime. Exponent bits beyond body[0] are dropped.
  - `frac` is ORed into the low `frac_len` bits (`frac_len` = N−1−ES−reg_len), only when `non_zero_frac_field_size`=1.
  - Stage 1 registers: body, sign, is_zero, is_nar, round_bit, sticky_bit, k_is_oob.
- **Stage 2 (round and sign)**
  - inc = round_bit & (sticky_bit | body[0]) & ~k_is_oob & ~(&body).
  - Rounding therefore never promotes maxpos to NaR. It never demotes to zero either, because body is non-zero for every legal k.
  - rbody = body + inc, computed N−1 bits wide; no carry-out is possible.
  - mag = {1'b0, rbody}.
  - posit = is_nar ? {1'b1, (N-1)'b0} : is_zero ? 0 : sign ? −mag (two's complement, N bits) : mag.
- **Handshake**
  - Each stage has a valid flag.
  - Stage 2 advances when ~s2_valid | out_ready.
  - Stage 1 advances into stage 2 when s1_valid and stage 2 advances.
  - in_ready = ~s1_valid | s1_advance. This is combinational and contains no dependency on in_valid.
  - A transfer occurs on in_valid & in_ready at the rising edge.
  - Stalled stage registers hold their values.
  - out_valid = s2_valid.
  - `posit` is stable while out_valid & ~out_ready.

## Timing
- Latency is 2 cycles from input accept to out_valid, with out_ready held high.
- Throughput is 1 result per cycle.
- **Reset** (asynchronous): s1_valid=0 and s2_valid=0, so out_valid=0; `posit`=0; all data registers cleared.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-flight discards both stages with no partial output.
- **Full pipeline with out_ready=0**: in_ready=0 in the same cycle; no input is lost or overwritten.
- **Simultaneous events**: out_ready rising while both stages are full and in_valid=1 shifts all three words in one edge (s2 out, s1→s2, in→s1).
- **Empty pipeline**: out_valid=0. `posit` holds its last value, or 0 after reset.

## Structure
- The shared package `ppu_pkg` holds:
  - K_SIZE = $clog2(N)+1 (signed);
  - MANT_SIZE;
  - REG_LEN_SIZE;
  - MANT_LEN_SIZE.
  - These are the same definitions `pack_fields` uses, so ports connect without casts.
- One sub-module, `build_body`: purely combinational stage-1 assembly (k, next_exp, frac, non_zero_frac_field_size → body). It is reusable by a future unpipelined encoder.
- The top level holds the two pipeline register banks, the rounding/sign logic and the handshake.

## Test plan
All cases use N=8, ES=0, with out_ready=1 unless stated.
- **Unity**: k=0, frac=0, round=sticky=0, sign=0 → posit=0x40 two cycles after accept.
- **Round to nearest-even**: k=0, frac=5'b10101, round=1, sticky=0 → body 1010101+1 → 0x56. Same input with frac=5'b10100 → 0x54 (tie to even, no increment).
- **Sign and specials**:
  - k=0, sign=1 → 0xC0.
  - is_nar=1 with is_zero=1 → 0x80.
  - is_zero=1 → 0x00.
- **Saturation**: k=6, k_is_oob=1, round=1, sticky=1 → 0x7F (maxpos), not 0x80. k=−6, round=0 → 0x01 (minpos).
- **Backpressure**:
  - Stream three words, then hold out_ready=0 for 3 cycles.
  - Required: in_ready drops once both stages are full, `posit` stays stable, and all words exit in order after release with none dropped or duplicated.
- **Reset mid-flight**: assert rst asynchronously with both stages full → out_valid and `posit` go to 0 immediately; the first output after release comes from a newly accepted input.
